fp_add_ctrl_module: RTL and testbench
=====================================

# fp_add_ctrl_module

Multi-cycle controller and datapath sequencer for IEEE-754 single-precision addition. Accepts two operands over a valid/ready handshake, then steps them through four phases: swap/unpack, exponent alignment, mantissa add/subtract, and normalization. Returns the packed result over a second valid/ready handshake. It feeds the FP unit's result path and reuses the existing one-position right-shift normalization rule for mantissa carry-out.

## Interface
- `W_EXP`, default 8: exponent width. Internal exponent register is `W_EXP+1` bits for overflow detection.
- `W_MAN`, default 23: stored mantissa width. Internal mantissa is `W_MAN+2` bits (carry, hidden, fraction).
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept operands. High only in IDLE.
- `a`, input, 32: operand A, IEEE-754.
- `b`, input, 32: operand B, IEEE-754.
- `out_valid`, output, 1: result valid. High only in DONE.
- `out_ready`, input, 1: consumer accepts result.
- `result`, output, 32: packed sum.
- `overflow`, output, 1: result exponent saturated to all-ones. Valid with `out_valid`.
- `busy`, output, 1: state other than IDLE.

## Operation
- **States:** IDLE, ALIGN, ADD, NORM, DONE. Reset forces IDLE.
- **Reset values:** `in_ready`=1, `out_valid`=0, `result`=0, `overflow`=0, `busy`=0. All internal registers are cleared.
- **IDLE, on `in_valid & in_ready` (accept edge):**
  - Unpack both operands. Hidden bit = 1 if exponent ≠ 0, else the operand is treated as zero (denormals flushed).
  - Order by magnitude `{exp,frac}`: larger magnitude goes to slot L, other to slot S. On equal magnitude, A stays in L.
  - Latch `d = expL - expS`. If `d > W_MAN+2`, clear `manS` and set `d = 0`.
  - Go to ALIGN.
- **ALIGN:** if `d ≠ 0`, shift `manS` right by 1, decrement `d`, and stay. If `d = 0`, go to ADD. Discarded bits are truncated.
- **ADD:**
  - Equal signs: `sum = manL + manS`.
  - Different signs: `sum = manL - manS` (never negative, by ordering).
  - Result sign = sign of L. `exp = expL` (9-bit). Go to NORM.
- **NORM**, evaluated one step per cycle:
  - `sum = 0`: result becomes +0. Go to DONE.
  - `sum[W_MAN+1] = 1`: shift `sum` right by 1, `exp += 1`. Go to DONE.
  - `sum[W_MAN] = 0`: shift `sum` left by 1, `exp -= 1`, and stay. If `exp` reaches 0, the result becomes +0 (underflow flush). Go to DONE.
  - Otherwise go to DONE.
- **DONE:**
  - `result = {sign, exp[7:0], sum[W_MAN-1:0]}`.
  - If `exp ≥ 255`: `result = {sign, 8'hFF, 0}` and `overflow = 1`.
  - Hold `result` and `overflow` stable while `out_ready` = 0. On `out_valid & out_ready`, go to IDLE.
- **Rounding:** truncation only.

## Timing
- Accept-to-`out_valid` latency is `d + k + 3` rising edges, where `d` is the post-clamp alignment count and `k` is the number of NORM left shifts. Minimum latency is 3.
- Throughput is one operation in flight. `in_ready` is low from the edge after accept until the edge after the DONE handshake.
- Back-to-back operation: the DONE handshake edge returns to IDLE, and a new accept can occur on the following edge.
- Asserting `rst_n` low in any state returns the block to IDLE immediately and discards the in-flight result. No `out_valid` pulse is produced.
- `in_valid` seen while not in IDLE is ignored. Operands are not captured.

## Configuration
- **`FPADD_SPECIAL_EN` defined:** in IDLE, an exponent of all-ones on either operand bypasses ALIGN/ADD/NORM and goes to DONE on the next edge (latency 1). `overflow` = 0 for these cases.
  - Any NaN operand, or +inf plus −inf, gives `0x7FC00000`.
  - Otherwise inf gives inf with the sign of the infinite operand.
- **`FPADD_SPECIAL_EN` undefined:** all-ones exponents are processed as ordinary numbers through the normal path.

## Test plan
- `0x3F800000 + 0x3F800000` → `0x40000000`, `overflow`=0. `out_valid` 3 edges after accept (NORM right shift).
- `0x3FC00000 + 0x3F400000` (1.5 + 0.75) → `0x40100000`, latency 4 (`d`=1).
- `0x3F800000 + 0xBF400000` (1.0 − 0.75) → `0x3E800000`, latency 6 (`d`=1, `k`=2). Also `0x3F800000 + 0xBF800000` → `0x00000000`, latency 3.
- `0x7F7FFFFF + 0x7F7FFFFF` → `0x7F800000`, `overflow`=1. Hold `out_ready`=0 for 5 cycles: `result` stable, `in_ready`=0, and `in_valid` pulses are ignored.
- Pull `rst_n` low while in NORM during a `k`=2 case: all outputs read 0 and `in_ready`=1 immediately. The next operation `0x40000000 + 0x40000000` → `0x40800000`.
- With `FPADD_SPECIAL_EN`: `0x7F800000 + 0xFF800000` → `0x7FC00000`, latency 1. Without it: the same inputs produce a finite-path result and no X on outputs.

Source files
------------

// File: rtl/fp_add_ctrl_module_if.sv
// Operand/result handshake bundle for fp_add_ctrl_module.
// master: operand producer / result consumer. slave: the adder controller.
interface fp_add_ctrl_module_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/fp_add_ctrl_module.sv
// Multi-cycle IEEE-754 single-precision adder sequencer: unpack/swap, one-bit-per-cycle
// alignment, add/sub, one-bit-per-cycle normalization, truncating rounding.
// Optional FPADD_SPECIAL_EN: inf/NaN operands bypass the datapath and finish in one cycle.
module fp_add_ctrl_module #(
  parameter int unsigned W_EXP = 8,
  parameter int unsigned W_MAN = 23
) (
  input logic                 clk,
  input logic                 rst_n,
  fp_add_ctrl_module_if.slave bus
);
  localparam int unsigned W  = 1 + W_EXP + W_MAN;
  localparam int unsigned WM = W_MAN + 2;  // carry, hidden, fraction
  localparam int unsigned WE = W_EXP + 1;  // extra bit catches exponent overflow
  localparam logic [W_EXP-1:0] DMax = W_EXP'(W_MAN + 2);

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} state_e;

  state_e           state_q, state_d;
  logic             sign_l_q, sign_l_d, sign_s_q, sign_s_d;
  logic [WE-1:0]    exp_q, exp_d;
  logic [WM-1:0]    man_l_q, man_l_d, man_s_q, man_s_d, sum_q, sum_d;
  logic [W_EXP-1:0] d_q, d_d;
  logic [W-1:0]     result_q, result_d;
  logic             overflow_q, overflow_d;

  // Operand unpack; denormals (exponent 0) are flushed to a zero mantissa.
  logic             sign_a, sign_b, a_is_l;
  logic [W_EXP-1:0] exp_a, exp_b, exp_big, exp_small, exp_diff;
  logic [W_MAN-1:0] frac_a, frac_b;
  logic [WM-1:0]    man_a, man_b;

  assign sign_a    = bus.a[W-1];
  assign sign_b    = bus.b[W-1];
  assign exp_a     = bus.a[W-2:W_MAN];
  assign exp_b     = bus.b[W-2:W_MAN];
  assign frac_a    = bus.a[W_MAN-1:0];
  assign frac_b    = bus.b[W_MAN-1:0];
  assign man_a     = (exp_a != '0) ? {1'b0, 1'b1, frac_a} : '0;
  assign man_b     = (exp_b != '0) ? {1'b0, 1'b1, frac_b} : '0;
  // Magnitude order on {exp,frac}; ties keep A in the large slot.
  assign a_is_l    = bus.a[W-2:0] >= bus.b[W-2:0];
  assign exp_big   = a_is_l ? exp_a : exp_b;
  assign exp_small = a_is_l ? exp_b : exp_a;
  assign exp_diff  = exp_big - exp_small;

`ifdef FPADD_SPECIAL_EN
  logic         nan_a, nan_b, inf_a, inf_b, special;
  logic [W-1:0] special_res;

  assign nan_a       = (exp_a == '1) && (frac_a != '0);
  assign nan_b       = (exp_b == '1) && (frac_b != '0);
  assign inf_a       = (exp_a == '1) && (frac_a == '0);
  assign inf_b       = (exp_b == '1) && (frac_b == '0);
  assign special     = (exp_a == '1) || (exp_b == '1);
  assign special_res = (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b)))
                     ? {1'b0, {W_EXP{1'b1}}, 1'b1, {(W_MAN-1){1'b0}}}
                     : {(inf_a ? sign_a : sign_b), {W_EXP{1'b1}}, {W_MAN{1'b0}}};
`endif

  // Normalization step helpers.
  logic [WE-1:0] exp_inc, exp_dec;
  logic [WM-1:0] sum_shr, sum_shl;

  assign exp_inc = exp_q + 1'b1;
  assign exp_dec = exp_q - 1'b1;
  assign sum_shr = sum_q >> 1;
  assign sum_shl = sum_q << 1;

  // Returns {overflow, packed result}; saturates to signed infinity when the exponent is full.
  function automatic logic [W:0] pack(input logic s, input logic [WE-1:0] e,
                                      input logic [WM-1:0] m);
    logic [WE-1:0] e_max;
    e_max = {1'b0, {W_EXP{1'b1}}};
    if (e >= e_max) pack = {1'b1, s, {W_EXP{1'b1}}, {W_MAN{1'b0}}};
    else            pack = {1'b0, s, e[W_EXP-1:0], m[W_MAN-1:0]};
  endfunction

  // Next-state and datapath sequencing.
  always_comb begin
    state_d    = state_q;
    sign_l_d   = sign_l_q;
    sign_s_d   = sign_s_q;
    exp_d      = exp_q;
    man_l_d    = man_l_q;
    man_s_d    = man_s_q;
    sum_d      = sum_q;
    d_d        = d_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_l_d = a_is_l ? sign_a : sign_b;
          sign_s_d = a_is_l ? sign_b : sign_a;
          exp_d    = {1'b0, exp_big};
          man_l_d  = a_is_l ? man_a : man_b;
          man_s_d  = a_is_l ? man_b : man_a;
          d_d      = exp_diff;
          // Small operand shifts out entirely; skip the alignment walk.
          if (exp_diff > DMax) begin
            man_s_d = '0;
            d_d     = '0;
          end
          state_d = StAlign;
`ifdef FPADD_SPECIAL_EN
          if (special) begin
            state_d    = StDone;
            result_d   = special_res;
            overflow_d = 1'b0;
          end
`endif
        end
      end
      StAlign: begin
        if (d_q != '0) begin
          man_s_d = man_s_q >> 1;
          d_d     = d_q - 1'b1;
        end else begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        // Ordering guarantees the difference is never negative.
        sum_d   = (sign_l_q == sign_s_q) ? man_l_q + man_s_q : man_l_q - man_s_q;
        state_d = StNorm;
      end
      StNorm: begin
        if (sum_q == '0) begin
          {overflow_d, result_d} = '0;
          state_d                = StDone;
        end else if (sum_q[WM-1]) begin
          {overflow_d, result_d} = pack(sign_l_q, exp_inc, sum_shr);
          state_d                = StDone;
        end else if (!sum_q[W_MAN]) begin
          sum_d = sum_shl;
          exp_d = exp_dec;
          // Exponent exhausted before the hidden bit came up: flush to +0.
          if (exp_dec == '0) begin
            {overflow_d, result_d} = '0;
            state_d                = StDone;
          end
        end else begin
          {overflow_d, result_d} = pack(sign_l_q, exp_q, sum_q);
          state_d                = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sign_l_q   <= 1'b0;
      sign_s_q   <= 1'b0;
      exp_q      <= '0;
      man_l_q    <= '0;
      man_s_q    <= '0;
      sum_q      <= '0;
      d_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_l_q   <= sign_l_d;
      sign_s_q   <= sign_s_d;
      exp_q      <= exp_d;
      man_l_q    <= man_l_d;
      man_s_q    <= man_s_d;
      sum_q      <= sum_d;
      d_q        <= d_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fp_add_ctrl_module.sv
// Directed and randomized checks of fp_add_ctrl_module against an arithmetic reference model.
module tb_fp_add_ctrl_module;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  fp_add_ctrl_module_if bus ();

  fp_add_ctrl_module dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  function automatic longint man_of(input logic [31:0] x);
    if (x[30:23] != 8'd0) return longint'(x[22:0]) + (64'sd1 <<< 23);
    return 0;
  endfunction

  // Reference: whole-operand arithmetic with one-shot shifts and a leading-zero count.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic o, output int lat);
    int     ex, ey, el, es, d, k, e;
    longint ml, ms, sum;
    logic   sl, ss;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    r  = 32'h0;
    o  = 1'b0;
`ifdef FPADD_SPECIAL_EN
    if (ex == 255 || ey == 255) begin
      lat = 1;
      if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
          (ex == 255 && ey == 255 && x[31] != y[31])) r = 32'h7FC00000;
      else if (ex == 255) r = {x[31], 8'hFF, 23'h0};
      else                r = {y[31], 8'hFF, 23'h0};
      return;
    end
`endif
    if (x[30:0] >= y[30:0]) begin
      el = ex; es = ey; sl = x[31]; ss = y[31]; ml = man_of(x); ms = man_of(y);
    end else begin
      el = ey; es = ex; sl = y[31]; ss = x[31]; ml = man_of(y); ms = man_of(x);
    end
    d = el - es;
    if (d > 25) begin
      ms = 0;
      d  = 0;
    end
    ms  = ms >> d;
    sum = (sl == ss) ? ml + ms : ml - ms;
    e   = el;
    lat = d + 3;
    if (sum == 0) return;
    if (sum >= (64'sd1 <<< 24)) begin
      sum = sum >> 1;
      e   = e + 1;
    end else begin
      k = 0;
      while (sum < (64'sd1 <<< 23)) begin
        sum = sum << 1;
        k++;
      end
      if (k >= el) begin
        lat = d + 2 + el;
        return;
      end
      e   = el - k;
      lat = d + k + 3;
    end
    if (e >= 255) begin
      r = {sl, 8'hFF, 23'h0};
      o = 1'b1;
    end else begin
      r = {sl, 8'(e), 23'(sum)};
    end
  endfunction

  // One transaction: accept, wait for out_valid, optionally stall the consumer, then drain.
  task automatic do_op(input logic [31:0] opa, input logic [31:0] opb, input int hold,
                       input logic [31:0] er, input logic eo, input int el);
    int lat;
    @(negedge clk);
    bus.a        = opa;
    bus.b        = opb;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    chk("in_ready_before_accept", bus.in_ready, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    chk("busy_after_accept", bus.busy, 32'd1);
    chk("in_ready_after_accept", bus.in_ready, 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 400);
    if (bus.out_valid !== 1'b1) begin
      chk("out_valid_timeout", bus.out_valid, 32'd1);
      summary();
    end
    chk("latency", lat, el);
    chk("result", bus.result, er);
    chk("overflow", bus.overflow, {31'h0, eo});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = i[0] ? 1'b0 : 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk);
      #1;
      chk("hold_result", bus.result, er);
      chk("hold_overflow", bus.overflow, {31'h0, eo});
      chk("hold_out_valid", bus.out_valid, 32'd1);
      chk("hold_in_ready", bus.in_ready, 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_out_valid", bus.out_valid, 32'd0);
    chk("drain_in_ready", bus.in_ready, 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic        eo;
    int          el, ea, eb, mode;
    bit          saw_valid;
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    #1;
    chk("rst_in_ready", bus.in_ready, 32'd1);
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_overflow", bus.overflow, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h3F800000, 32'h3F800000, 0, 32'h40000000, 1'b0, 3);
    do_op(32'h3FC00000, 32'h3F400000, 1, 32'h40100000, 1'b0, 4);
    do_op(32'h3F800000, 32'hBF400000, 0, 32'h3E800000, 1'b0, 6);
    do_op(32'h3F800000, 32'hBF800000, 0, 32'h00000000, 1'b0, 3);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 5, 32'h7F800000, 1'b1, 3);
    // Smallest normal exponent, cancellation needs two shifts: flush to +0 after one.
    do_op(32'h00C00000, 32'h80A00000, 0, 32'h00000000, 1'b0, 3);
`ifdef FPADD_SPECIAL_EN
    do_op(32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 1'b0, 1);
`else
    do_op(32'h7F800000, 32'hFF800000, 0, 32'h00000000, 1'b0, 3);
`endif

    // Reset while normalizing a two-shift case.
    @(negedge clk);
    bus.a        = 32'h3F800000;
    bus.b        = 32'hBF400000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_in_norm", bus.busy, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 32'd1);
    chk("midrst_out_valid", bus.out_valid, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_overflow", bus.overflow, 32'd0);
    chk("midrst_busy", bus.busy, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    saw_valid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) saw_valid = 1'b1;
    end
    chk("no_valid_after_rst", {31'h0, saw_valid}, 32'd0);
    do_op(32'h40000000, 32'h40000000, 0, 32'h40800000, 1'b0, 3);

    // Randomized operands biased toward near exponents, zeros, cancellation and all-ones.
    for (int i = 0; i < 40; i++) begin
      ea   = int'($urandom_range(1, 254));
      mode = int'($urandom_range(0, 7));
      ra   = {1'($urandom), 8'(ea), 23'($urandom)};
      case (mode)
        0:       eb = ea;
        1:       eb = 0;
        3:       eb = 255;
        default: eb = ea + int'($urandom_range(0, 60)) - 30;
      endcase
      if (eb < 0)   eb = 0;
      if (eb > 255) eb = 255;
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      if (mode == 2) rb = {~ra[31], ra[30:0]};
      model(ra, rb, er, eo, el);
      do_op(ra, rb, int'($urandom_range(0, 2)), er, eo, el);
    end

    summary();
  end
endmodule
